// File: rtl/alu_pkg.sv
// alu_pkg: operand/opcode and response types shared by the ALU wrapper, its issuer and benches
package alu_pkg;
    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
    } alu_rsp_t;
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command, ALU-wrapper and response signals of the issuer
interface alu_cmd_issuer_if;
    import alu_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_carry
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: single-clock FIFO, full/empty from extra pointer bit, output reads 0 when empty
module alu_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty   = wr_q == rd_q;
        count   = wr_q - rd_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        mem_d   = mem_q;
        mem_d[wr_q[AW-1:0]] = do_push ? din : mem_q[wr_q[AW-1:0]];
        dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, issues one per cycle against response credits,
// and collects results ALU_LAT edges later into an in-order response FIFO.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 3
) (
    input logic             clk,
    input logic             rst_n,
    alu_cmd_issuer_if.slave bus
);
    localparam int CW = $clog2(RSP_DEPTH + ALU_LAT + 1) + 1;

    alu_cmd_t                   cmd_in, cmd_out, alu_q, alu_d;
    alu_rsp_t                   rsp_in, rsp_out;
    logic                       cmd_full, cmd_empty, cmd_push;
    logic                       rsp_full, rsp_empty, rsp_pop;
    logic                       issue, retire;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic [$clog2(RSP_DEPTH):0] rsp_count;
    logic [CW-1:0]              inflight, credit_used;
    logic [ALU_LAT-1:0]         track_q, track_d;

    assign cmd_in   = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
    assign rsp_in   = '{result: bus.alu_result, carry: bus.alu_carry};
    assign cmd_push = bus.cmd_valid && !cmd_full;
    assign rsp_pop  = bus.rsp_ready && !rsp_empty;
    assign retire   = track_q[ALU_LAT-1];

    alu_sync_fifo #(.W($bits(alu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst_n(rst_n), .push(cmd_push), .din(cmd_in), .pop(issue),
        .dout(cmd_out), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    alu_sync_fifo #(.W($bits(alu_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(clk), .rst_n(rst_n), .push(retire), .din(rsp_in), .pop(rsp_pop),
        .dout(rsp_out), .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
    );

    // A retiring bit still holds its credit: its result lands in the FIFO at this edge.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ALU_LAT; i++) inflight = inflight + CW'(track_q[i]);
        credit_used = inflight + CW'(rsp_count) - CW'(rsp_pop);
        issue   = !cmd_empty && (credit_used < CW'(RSP_DEPTH));
        track_d = (track_q << 1) | ALU_LAT'(issue);
        alu_d   = issue ? cmd_out : alu_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_q <= '0;
            alu_q   <= '0;
        end else begin
            track_q <= track_d;
            alu_q   <= alu_d;
        end
    end

    assign bus.cmd_ready  = !cmd_full;
    assign bus.alu_a      = alu_q.a;
    assign bus.alu_b      = alu_q.b;
    assign bus.alu_op     = alu_q.op;
    assign bus.rsp_valid  = !rsp_empty;
    assign bus.rsp_result = rsp_out.result;
    assign bus.rsp_carry  = rsp_out.carry;

    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(retire && rsp_full));
    a_cmd_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_count <= ($clog2(CMD_DEPTH) + 1)'(CMD_DEPTH));
endmodule
